// File: rtl/dff6.sv
// ---------------------------------------------------------------------------
// dff6 - positive-edge D flip-flop with complementary outputs.
//
// Resettable storage cell with both polarities available. WIDTH bits are
// stored independently; each bit is a master/slave pair of latches.
//
// Ports:
//   clk   in   1      clock, capture on rising edge
//   reset in   1      asynchronous active-low reset (0 = reset asserted)
//   d     in   WIDTH  data input
//   q     out  WIDTH  registered data
//   qb    out  WIDTH  bitwise complement of q, taken from the slave's
//                     own complementary node
//
// Parameters:
//   WIDTH        number of stored bits (default 1)
//   RESET_VALUE  value forced into q during reset; qb gets its complement
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module dff6 #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        logic r_m;
        logic r_mb;
        logic r_s;
        logic r_sb;

        // Master latch: follows d while clk is low, closes on the rising edge.
        // Reset forces it too, so a rising edge that coincides with the
        // release of reset can only pass the reset value to the slave.
        always_latch begin
            if (!reset) begin
                r_m  <= RESET_VALUE[g];
                r_mb <= ~RESET_VALUE[g];
            end else if (!clk) begin
                r_m  <= d[g];
                r_mb <= ~d[g];
            end
        end

        // Slave latch: copies both master nodes while clk is high, so the
        // true and complement outputs move together and never from an
        // inverter placed after q.
        always_latch begin
            if (!reset) begin
                r_s  <= RESET_VALUE[g];
                r_sb <= ~RESET_VALUE[g];
            end else if (clk) begin
                r_s  <= r_m;
                r_sb <= r_mb;
            end
        end

        assign q[g]  = r_s;
        assign qb[g] = r_sb;
    end

endmodule

// File: tb/tb_dff6.sv
`timescale 1ns/1ps

module tb_dff6;

    localparam int         W2  = 4;
    localparam logic [3:0] RV2 = 4'b1010;

    logic          clk;
    logic          reset;
    logic [0:0]    d;
    logic [0:0]    q;
    logic [0:0]    qb;

    logic          reset2;
    logic [W2-1:0] d2;
    logic [W2-1:0] q2;
    logic [W2-1:0] qb2;

    int checks;
    int errors;

    typedef struct {
        int   drive;   // integer driven onto the 1-bit d (only LSB used)
        logic exp_q;   // value q must show after the next rising edge
    } vec_t;

    vec_t vecs[5];

    dff6 dut1 (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q),
        .qb    (qb)
    );

    dff6 #(.WIDTH(W2), .RESET_VALUE(RV2)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .d     (d2),
        .q     (q2),
        .qb    (qb2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare q and qb of a DUT against the expected q (and its complement).
    task automatic check(input string name, input logic [7:0] got_q,
                         input logic [7:0] got_qb, input logic [7:0] exp_q,
                         input logic [7:0] mask);
        logic [7:0] exp_qb;
        exp_qb = (~exp_q) & mask;
        checks++;
        if (got_q !== (exp_q & mask)) begin
            errors++;
            $display("FAIL %s q: got %h expected %h at %0t", name, got_q, exp_q & mask, $time);
        end
        checks++;
        if (got_qb !== exp_qb) begin
            errors++;
            $display("FAIL %s qb: got %h expected %h at %0t", name, got_qb, exp_qb, $time);
        end
    endtask

    task automatic chk1(input string name, input logic exp_q);
        check(name, {7'b0, q}, {7'b0, qb}, {7'b0, exp_q}, 8'h01);
    endtask

    task automatic chk2(input string name, input logic [W2-1:0] exp_q);
        check(name, {4'b0, q2}, {4'b0, qb2}, {4'b0, exp_q}, 8'h0F);
    endtask

    initial begin
        int         n;
        logic [31:0] tmp;
        logic [W2-1:0] model_q;
        logic [W2-1:0] prev_d;

        checks = 0;
        errors = 0;

        for (int i = 0; i < 5; i++) begin
            vecs[i].drive = i;
            tmp           = i;
            vecs[i].exp_q = tmp[0];
        end

        // Power-up: reset held, d unknown, clock running.
        reset  = 1'b0;
        d      = 1'bx;
        reset2 = 1'b0;
        d2     = '0;
        n = 3 + $urandom_range(0, 3);
        repeat (n) begin
            @(negedge clk);
            chk1("powerup_hold", 1'b0);
        end

        // Release mid-cycle with d = 1: nothing until the next rising edge.
        d = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk1("release_no_capture", 1'b0);
        @(posedge clk);
        #1 chk1("release_first_edge", 1'b1);

        // Asynchronous reset between edges takes effect immediately.
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk1("async_reset_immediate", 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk1("async_reset_hold", 1'b0);
        end

        // Second release.
        #2 reset = 1'b1;
        @(posedge clk);
        #1 chk1("second_release", 1'b1);

        // Table-driven data stream with changes between edges.
        foreach (vecs[i]) begin
            @(negedge clk);
            #($urandom_range(1, 4));
            tmp = vecs[i].drive;
            d   = tmp[0];
            @(posedge clk);
            #1 chk1("stream_capture", vecs[i].exp_q);
            d = ~tmp[0];
            #1 chk1("stream_between_edges", vecs[i].exp_q);
        end

        // Reset released exactly on a rising edge: that edge must not capture.
        @(negedge clk);
        #2 reset = 1'b0;
        d = 1'b1;
        #1 chk1("coincide_pre", 1'b0);
        @(posedge clk);
        reset = 1'b1;
        #1 chk1("coincide_edge", 1'b0);
        @(posedge clk);
        #1 chk1("coincide_next_edge", 1'b1);

        // Randomised run on the 4-bit instance against a simple model:
        // q is the reset value while reset is low, else the last d seen at
        // a rising edge with reset high.
        model_q = RV2;
        chk2("w4_reset_state", model_q);
        for (int it = 0; it < 150; it++) begin
            @(negedge clk);
            #($urandom_range(1, 2));
            reset2 = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            prev_d = d2;
            d2     = W2'($urandom);
            #1;
            if (!reset2) model_q = RV2;
            chk2("w4_mid_cycle", model_q);
            @(posedge clk);
            #1;
            if (reset2) model_q = d2;
            chk2("w4_after_edge", model_q);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff6.md
Name: dff6

Overview:
- Single-clock, positive-edge D flip-flop with complementary outputs q and qb.
- Asynchronous, active-low reset.
- Leaf storage cell used wherever a resettable registered bit with both polarities is needed.
- Width is parameterised so the same cell also serves as a small register; default is one bit.

Parameters:
- WIDTH, 1, number of stored bits; d, q and qb are all WIDTH bits.
- RESET_VALUE, all-zeros, value loaded into q while reset is asserted; qb loads its bitwise complement.

Ports:
- clk  input  1  clock; all capture happens on the rising edge.
- reset  input  1  asynchronous, active-low reset. 0 = reset asserted, 1 = normal operation.
- d  input  WIDTH  data input.
- q  output  WIDTH  registered data.
- qb  output  WIDTH  bitwise complement of q.

Behaviour:
- Reset assertion (reset falls to 0):
  - q = RESET_VALUE and qb = ~RESET_VALUE immediately, with no clock needed.
  - Both hold for as long as reset stays 0, regardless of clk and d.
- Reset deassertion (reset rises to 1):
  - Outputs keep their reset values until the first rising clk edge at which reset is already 1.
  - No capture happens on the release itself.
- Reset is dominant: a rising clk edge that coincides with reset = 0 or a falling reset leaves the reset values in place.
- Normal operation:
  - On each rising clk edge with reset = 1: q <= d and qb <= ~d.
  - Latency is one clock edge; outputs are stable between edges.
  - Changes on d between edges have no effect on the outputs.
- Invariant: qb == ~q at all times, including during reset and across every transition. There is no cycle in which q and qb are both 0 or both 1, as long as all inputs are known.
- Width rule: d is exactly WIDTH bits and no internal extension or truncation is performed. The driver is responsible for narrowing wider sources, i.e. only the LSBs of an integer driven to a 1-bit instance are used.
- Unknown inputs:
  - An X/Z bit of d sampled at an edge yields X on that q bit and the corresponding qb bit.
  - An X bit of d while reset = 0 is ignored.
- Implementation:
  - Build as a structural master-slave pair of gate-level latches per bit: master transparent while clk = 0, slave transparent while clk = 1.
  - Reset is forced into both latches through set/clear gating.
  - qb is taken from the slave latch's complementary node, not from a separate inverter on q.
  - Per-bit cells are generated over WIDTH.
- No enable, no scan, no synchronous reset.

Test Plan:
- Power-up reset: clk toggling at 10-time-unit period, reset = 0, d = X for a random delay -> q = 0 and qb = 1 throughout, with no X on outputs.
- Release and capture: d = 1, then reset 0->1 mid-cycle -> outputs stay q = 0, qb = 1 until the next rising edge, then q = 1, qb = 0.
- Async reset mid-operation: with q = 1, drive reset = 0 between clock edges -> q = 0 and qb = 1 immediately, before any clock edge. Outputs hold while clk keeps toggling with d = 1.
- Second release: reset back to 1 with d = 1 -> q = 1 on the first following rising edge.
- Data stream: d driven with the LSBs of 0,1,2,3,4 at random non-edge-aligned times -> at each rising edge q equals the d sampled there (0,1,0,1,0) and qb its complement. d changes between edges are not visible until the next edge.
- Simultaneous reset release and rising clk edge, with d = 1 -> q stays 0 for that edge and becomes 1 on the next edge. Check qb == ~q at every sample point.
